// File: rtl/axi_traffic_generator.sv
// AXI4 master that replays a fixed write-then-read INCR burst sequence,
// checks every B and R response and counts the bad ones.
module axi_traffic_generator #(
   parameter int unsigned           ID_WIDTH   = 4,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 64,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h1000,
   parameter int unsigned           NUM_TXN    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic [ID_WIDTH-1:0]     awid,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [7:0]              awlen,
   output logic [2:0]              awsize,
   output logic [1:0]              awburst,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [ID_WIDTH-1:0]     bid,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [ID_WIDTH-1:0]     arid,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic [7:0]              arlen,
   output logic [2:0]              arsize,
   output logic [1:0]              arburst,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [ID_WIDTH-1:0]     rid,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rlast,
   input  logic                    rvalid,
   output logic                    rready,
   output logic                    done,
   output logic [15:0]             err_count
);

   localparam logic [2:0]  SIZE  = 3'($clog2(DATA_WIDTH / 8));
   localparam logic [31:0] NUM_W = 32'(NUM_TXN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_ADDR,
      S_WR_DATA,
      S_WR_RESP,
      S_RD_ADDR,
      S_RD_DATA,
      S_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic                    arm_q, arm_d;
   logic [31:0]             k_q, k_d;
   logic [7:0]              beat_q, beat_d;
   logic                    bdone_q, bdone_d;
   logic [15:0]             err_q, err_d;

   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    bready_q, bready_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rready_q, rready_d;
   logic                    done_q, done_d;
   logic [ID_WIDTH-1:0]     id_q, id_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [7:0]              len_q, len_d;
   logic [2:0]              size_q, size_d;
   logic [1:0]              burst_q, burst_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
   logic                    wlast_q, wlast_d;

   logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic [ID_WIDTH-1:0]     cur_id;
   logic [7:0]              cur_len;
   logic                    at_len;
   logic [1:0]              inc;
   logic [16:0]             sum;
   logic                    unused_rdata;

   assign aw_hs   = awvalid_q & awready;
   assign w_hs    = wvalid_q & wready;
   assign b_hs    = bready_q & bvalid;
   assign ar_hs   = arvalid_q & arready;
   assign r_hs    = rready_q & rvalid;
   assign cur_id  = k_q[ID_WIDTH-1:0];
   assign cur_len = {6'd0, k_q[1:0]};
   assign at_len  = (beat_q == cur_len);

   assign unused_rdata = ^rdata;

   // State and datapath registers; every output comes straight from a flop
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         arm_q     <= 1'b0;
         k_q       <= '0;
         beat_q    <= '0;
         bdone_q   <= 1'b0;
         err_q     <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         done_q    <= 1'b0;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wlast_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         arm_q     <= arm_d;
         k_q       <= k_d;
         beat_q    <= beat_d;
         bdone_q   <= bdone_d;
         err_q     <= err_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         done_q    <= done_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         size_q    <= size_d;
         burst_q   <= burst_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         wlast_q   <= wlast_d;
      end
   end

   // Sequencer: walks each write/read pair, counts beats and errors
   always_comb begin
      state_d = state_q;
      arm_d   = 1'b1;
      k_d     = k_q;
      beat_d  = beat_q;
      bdone_d = bdone_q;
      inc     = 2'd0;
      unique case (state_q)
         S_IDLE: begin
            if (arm_q) state_d = S_WR_ADDR;
         end
         S_WR_ADDR: begin
            if (aw_hs) begin
               state_d = S_WR_DATA;
               beat_d  = '0;
               bdone_d = 1'b0;
            end
         end
         S_WR_DATA: begin
            if (w_hs) begin
               if (at_len) begin
                  state_d = (bdone_q | b_hs) ? S_RD_ADDR : S_WR_RESP;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         S_WR_RESP: begin
            if (b_hs) state_d = S_RD_ADDR;
         end
         S_RD_ADDR: begin
            if (ar_hs) begin
               state_d = S_RD_DATA;
               beat_d  = '0;
            end
         end
         S_RD_DATA: begin
            if (r_hs) begin
               if (rresp != 2'b00 || rid != cur_id) inc = inc + 2'd1;
               if (rlast != at_len) inc = inc + 2'd1;
               if (rlast || at_len) begin
                  k_d = k_q + 32'd1;
                  if (NUM_W != 32'd0 && k_q + 32'd1 == NUM_W) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_WR_ADDR;
                  end
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      if (b_hs) begin
         bdone_d = 1'b1;
         if (bresp != 2'b00 || bid != cur_id) inc = inc + 2'd1;
      end
      sum   = {1'b0, err_q} + {15'd0, inc};
      err_d = sum[16] ? 16'hFFFF : sum[15:0];
   end

   // Next values of the registered outputs, derived from the next state
   always_comb begin
      awvalid_d = (state_d == S_WR_ADDR);
      wvalid_d  = (state_d == S_WR_DATA);
      arvalid_d = (state_d == S_RD_ADDR);
      rready_d  = (state_d == S_RD_DATA);
      done_d    = (state_d == S_DONE);
      bready_d  = bready_q;
      if (aw_hs) bready_d = 1'b1;
      if (b_hs) bready_d = 1'b0;
      id_d    = k_d[ID_WIDTH-1:0];
      addr_d  = BASE_ADDR + ADDR_WIDTH'({k_d, 8'h00});
      len_d   = {6'd0, k_d[1:0]};
      size_d  = SIZE;
      burst_d = 2'b01;
      wdata_d = DATA_WIDTH'({k_d[15:0], 8'h00, beat_d});
      wstrb_d = '1;
      wlast_d = (beat_d == len_d);
   end

   assign awid      = id_q;
   assign awaddr    = addr_q;
   assign awlen     = len_q;
   assign awsize    = size_q;
   assign awburst   = burst_q;
   assign awvalid   = awvalid_q;
   assign wdata     = wdata_q;
   assign wstrb     = wstrb_q;
   assign wlast     = wlast_q;
   assign wvalid    = wvalid_q;
   assign bready    = bready_q;
   assign arid      = id_q;
   assign araddr    = addr_q;
   assign arlen     = len_q;
   assign arsize    = size_q;
   assign arburst   = burst_q;
   assign arvalid   = arvalid_q;
   assign rready    = rready_q;
   assign done      = done_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_axi_traffic_generator.sv
// Bench for axi_traffic_generator: scripted slave plus a scoreboard
// monitor that checks AW/W/AR payloads as they handshake.
module tb_axi_traffic_generator;

   logic        clk;
   logic        rst;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic        done;
   logic [15:0] err_count;

   axi_traffic_generator #(.NUM_TXN(4)) dut (
      .clk(clk), .rst(rst),
      .awid(awid), .awaddr(awaddr), .awlen(awlen),
      .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp),
      .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp),
      .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .done(done), .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int ncmp = 0;
   int nerr = 0;

   logic [48:0] exp_aw[$];
   logic [72:0] exp_w[$];
   logic [48:0] exp_ar[$];

   int aw_wait;
   int w_toggle;
   int early_b;
   int bresp_bad_k;
   int rid_bad_k;
   int aw_stall_seen;

   task automatic chk(input string nm,
                      input logic [127:0] act,
                      input logic [127:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic push_txn(input int k,
                           input logic [31:0] addr,
                           input logic [7:0] len);
      exp_aw.push_back({4'(k), addr, len, 3'd3, 2'd1});
      for (int b = 0; b <= int'(len); b++) begin
         exp_w.push_back({(b == int'(len)), 8'hFF,
                          64'(k * 65536 + b)});
      end
      exp_ar.push_back({4'(k), addr, len, 3'd3, 2'd1});
   endtask

   task automatic push_all();
      push_txn(0, 32'h1000, 8'd0);
      push_txn(1, 32'h1100, 8'd1);
      push_txn(2, 32'h1200, 8'd2);
      push_txn(3, 32'h1300, 8'd3);
   endtask

   task automatic cfg_default();
      aw_wait       = 0;
      w_toggle      = 0;
      early_b       = 0;
      bresp_bad_k   = -1;
      rid_bad_k     = -1;
      aw_stall_seen = 0;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valids",
          128'({awvalid, wvalid, bready, arvalid, rready, done}),
          128'(0));
      chk("rst_payload",
          128'({awaddr, awlen, awid, awsize, awburst,
                wstrb, wlast, wdata[31:0], araddr[15:0]}),
          128'(0));
      chk("rst_err", 128'(err_count), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_cycle", 128'(awvalid), 128'(0));
      @(posedge clk);
      #1;
      chk("first_aw", 128'({awvalid, awaddr, awid}),
          128'({1'b1, 32'h1000, 4'h0}));
   endtask

   task automatic finish_scn(input logic [15:0] exp_err);
      int n;
      n = 0;
      while (!done && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("done", 128'(done), 128'(1));
      chk("err_count", 128'(err_count), 128'(exp_err));
      chk("done_quiet",
          128'({awvalid, wvalid, bready, arvalid, rready}),
          128'(0));
      chk("queues_drained",
          128'(exp_aw.size() + exp_w.size() + exp_ar.size()),
          128'(0));
      exp_aw.delete();
      exp_w.delete();
      exp_ar.delete();
   endtask

   // Scripted slave: samples handshakes at negedge, drives after posedge
   initial begin : slave
      logic       s_aw, s_wl, s_b, s_ar, s_r;
      logic [3:0] s_awid, s_arid;
      logic [7:0] s_arlen;
      int         b_k, r_left, r_beat, r_k;
      b_k = 0; r_left = 0; r_beat = 0; r_k = 0;
      awready = 1'b1; wready = 1'b1;
      bvalid = 1'b0; bid = '0; bresp = '0;
      arready = 1'b1; rvalid = 1'b0; rid = '0;
      rdata = '0; rresp = '0; rlast = 1'b0;
      forever begin
         @(negedge clk);
         s_aw    = awvalid && awready;
         s_awid  = awid;
         s_wl    = wvalid && wready && wlast;
         s_b     = bvalid && bready;
         s_ar    = arvalid && arready;
         s_arid  = arid;
         s_arlen = arlen;
         s_r     = rvalid && rready;
         @(posedge clk);
         #1;
         if (rst) begin
            bvalid  = 1'b0;
            rvalid  = 1'b0;
            rlast   = 1'b0;
            r_left  = 0;
            wready  = 1'b1;
            awready = (aw_wait == 0);
            continue;
         end
         awready = (aw_wait == 0);
         if (awvalid && aw_wait > 0) aw_wait--;
         wready = (w_toggle != 0) ? !wready : 1'b1;
         if (s_aw) b_k = int'(s_awid);
         if (s_b) bvalid = 1'b0;
         if ((early_b != 0 && s_aw) || (early_b == 0 && s_wl)) begin
            bvalid = 1'b1;
            bid    = 4'(b_k);
            bresp  = (b_k == bresp_bad_k) ? 2'b10 : 2'b00;
         end
         if (s_r) begin
            r_left--;
            r_beat++;
         end
         if (s_ar) begin
            r_left = int'(s_arlen) + 1;
            r_beat = 0;
            r_k    = int'(s_arid);
         end
         rvalid = (r_left > 0);
         rlast  = (r_left == 1);
         rid    = (r_k == rid_bad_k && r_beat == 0) ? 4'd5 : 4'(r_k);
         rresp  = 2'b00;
         rdata  = {$urandom, $urandom};
      end
   end

   // Scoreboard monitor: pops expectations on every AW/W/AR handshake
   initial begin : monitor
      logic [48:0] aw_now, aw_prev, ar_now;
      logic [72:0] w_now, w_prev;
      logic        aw_pend, w_pend, wfin;
      aw_pend = 1'b0; w_pend = 1'b0; wfin = 1'b0;
      aw_prev = '0; w_prev = '0;
      forever begin
         @(negedge clk);
         aw_now = {awid, awaddr, awlen, awsize, awburst};
         w_now  = {wlast, wstrb, wdata};
         ar_now = {arid, araddr, arlen, arsize, arburst};
         if (aw_pend) begin
            chk("aw_stable", 128'({awvalid, aw_now}),
                128'({1'b1, aw_prev}));
         end
         if (w_pend) begin
            chk("w_stable", 128'({wvalid, w_now}),
                128'({1'b1, w_prev}));
         end
         if (awvalid && !awready) aw_stall_seen++;
         aw_pend = awvalid && !awready;
         aw_prev = aw_now;
         w_pend  = wvalid && !wready;
         w_prev  = w_now;
         if (awvalid && awready) begin
            wfin = 1'b0;
            chk("aw_expected", 128'(exp_aw.size() != 0), 128'(1));
            if (exp_aw.size() != 0) begin
               chk("aw", 128'(aw_now), 128'(exp_aw.pop_front()));
            end
         end
         if (wvalid && wready) begin
            chk("w_expected", 128'(exp_w.size() != 0), 128'(1));
            if (exp_w.size() != 0) begin
               chk("w", 128'(w_now), 128'(exp_w.pop_front()));
            end
            if (wlast) wfin = 1'b1;
         end
         if (arvalid && arready) begin
            chk("ar_after_wlast", 128'(wfin), 128'(1));
            chk("ar_expected", 128'(exp_ar.size() != 0), 128'(1));
            if (exp_ar.size() != 0) begin
               chk("ar", 128'(ar_now), 128'(exp_ar.pop_front()));
            end
         end
      end
   end

   initial begin : stim
      logic found;
      rst = 1'b1;
      cfg_default();

      // always-ready slave, all four pairs
      push_all();
      reset_dut();
      finish_scn(16'd0);

      // awready held low for three cycles on txn0
      cfg_default();
      aw_wait = 3;
      push_all();
      reset_dut();
      finish_scn(16'd0);
      chk("aw_stall_cycles", 128'(aw_stall_seen), 128'(3));

      // wready toggling every cycle
      cfg_default();
      w_toggle = 1;
      push_all();
      reset_dut();
      finish_scn(16'd0);

      // bad bresp on txn0, bad rid on first beat of txn1 read
      cfg_default();
      bresp_bad_k = 0;
      rid_bad_k   = 1;
      push_all();
      reset_dut();
      finish_scn(16'd2);

      // B returned one cycle after AW, before W completes
      cfg_default();
      early_b = 1;
      push_all();
      reset_dut();
      finish_scn(16'd0);

      // reset in the middle of txn2's write burst
      cfg_default();
      push_txn(0, 32'h1000, 8'd0);
      push_txn(1, 32'h1100, 8'd1);
      exp_aw.push_back({4'd2, 32'h1200, 8'd2, 3'd3, 2'd1});
      exp_w.push_back({1'b0, 8'hFF, 64'h0000_0000_0002_0000});
      exp_w.push_back({1'b0, 8'hFF, 64'h0000_0000_0002_0001});
      reset_dut();
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk);
         if (wvalid && awid == 4'd2 && wdata[15:0] == 16'd1) begin
            found = 1'b1;
         end
      end
      chk("reach_txn2_beat1", 128'(found), 128'(1));
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_valids",
          128'({awvalid, wvalid, bready, arvalid, rready, done}),
          128'(0));
      chk("midrst_err", 128'(err_count), 128'(0));
      @(negedge clk);
      chk("midrst_queues",
          128'(exp_aw.size() + exp_w.size() + exp_ar.size()),
          128'(0));
      exp_aw.delete();
      exp_w.delete();
      exp_ar.delete();
      push_all();
      reset_dut();
      finish_scn(16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nerr);
      $finish;
   end

endmodule
